// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the Pong ball controller:
//               FSM state encoding, signed coordinate types, playfield
//               geometry, ball speed and game rules, plus small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Ball coordinates: signed so that "pos - size" near the left/top edge
  // goes negative instead of wrapping.
  typedef logic signed [10:0] coord_t;
  // Paddle extents: centre + half-extent of two 10-bit inputs needs 11
  // magnitude bits, so box tests run one bit wider.
  typedef logic signed [11:0] wcoord_t;

  localparam coord_t BALL_SIZE = 11'sd4;
  localparam coord_t X_MIN     = 11'sd0;
  localparam coord_t X_MAX     = 11'sd639;
  localparam coord_t Y_MIN     = 11'sd0;
  localparam coord_t Y_MAX     = 11'sd479;
  localparam coord_t CENTER_X  = 11'sd320;
  localparam coord_t CENTER_Y  = 11'sd240;
  localparam coord_t STEP      = 11'sd2;

  localparam int                SERVE_FRAMES = 60;
  localparam int                CNT_W        = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]  SERVE_LAST   = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]        WIN_SCORE    = 4'd9;

  // Inclusive 1-D interval overlap.
  function automatic logic spans_overlap(input wcoord_t a_lo, input wcoord_t a_hi,
                                         input wcoord_t b_lo, input wcoord_t b_hi);
    return (a_lo <= b_hi) && (a_hi >= b_lo);
  endfunction

  function automatic wcoord_t box_lo(input logic [9:0] c, input logic [9:0] h);
    return $signed({2'b00, c}) - $signed({2'b00, h});
  endfunction

  function automatic wcoord_t box_hi(input logic [9:0] c, input logic [9:0] h);
    return $signed({2'b00, c}) + $signed({2'b00, h});
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_sync
// Description : Brings the asynchronous frame clock into the Clk domain
//               through two flops and emits a one-Clk pulse per rising edge
//               using a third history flop.
// Ports       : Clk       - system clock
//               Reset     - asynchronous active-high reset
//               frame_clk - frame clock, asynchronous to Clk
//               tick      - one-cycle pulse per frame_clk rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/pong_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_ctrl
// Description : Pong ball sequencer. Once per frame it moves the ball,
//               bounces it off walls and paddles, detects misses, keeps the
//               scores and runs the IDLE/SERVE/PLAY/POINT/OVER flow.
// Ports       : Clk, Reset           - clock, async active-high reset
//               frame_clk            - frame clock (async to Clk)
//               serve_btn            - start / restart request (level)
//               Paddle{1,2}{X,Y,L,W} - paddle centres and half-extents
//               BallX, BallY         - ball centre
//               Ball_size            - ball half-width (constant)
//               score1, score2       - left / right scores
//               game_over            - high in OVER
//               state_dbg            - encoded FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       serve_btn,
  input  logic [9:0] Paddle1X,
  input  logic [9:0] Paddle1Y,
  input  logic [9:0] Paddle1L,
  input  logic [9:0] Paddle1W,
  input  logic [9:0] Paddle2X,
  input  logic [9:0] Paddle2Y,
  input  logic [9:0] Paddle2L,
  input  logic [9:0] Paddle2W,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [2:0] state_dbg
);
  import pong_pkg::*;

  logic tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  state_e           state_q, state_d;
  coord_t           bx_q, bx_d, by_q, by_d;
  // Speed magnitude is always STEP, so only the direction is stored.
  logic             vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic             left_scored_q, left_scored_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      bx_q          <= CENTER_X;
      by_q          <= CENTER_Y;
      vx_neg_q      <= 1'b0;
      vy_neg_q      <= 1'b0;
      cnt_q         <= '0;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      left_scored_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      vx_neg_q      <= vx_neg_d;
      vy_neg_q      <= vy_neg_d;
      cnt_q         <= cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      left_scored_q <= left_scored_d;
    end
  end

  // ---- Vertical: wall bounce, then step and clamp into the playfield ----
  logic   w_vy_nxt_neg;
  coord_t w_y_sum, w_y_new;

  always_comb begin
    w_vy_nxt_neg = vy_neg_q;
    if (!vy_neg_q && (by_q + BALL_SIZE >= Y_MAX))
      w_vy_nxt_neg = 1'b1;
    else if (vy_neg_q && (by_q - BALL_SIZE <= Y_MIN))
      w_vy_nxt_neg = 1'b0;
    w_y_sum = by_q + (w_vy_nxt_neg ? -STEP : STEP);
    if (w_y_sum < Y_MIN + BALL_SIZE)
      w_y_new = Y_MIN + BALL_SIZE;
    else if (w_y_sum > Y_MAX - BALL_SIZE)
      w_y_new = Y_MAX - BALL_SIZE;
    else
      w_y_new = w_y_sum;
  end

  // ---- Horizontal: paddle hits outrank misses ----
  wcoord_t w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;
  logic    w_hit1, w_hit2, w_miss_l, w_miss_r, w_vx_nxt_neg;
  coord_t  w_x_new;

  assign w_bx_lo = wcoord_t'(bx_q - BALL_SIZE);
  assign w_bx_hi = wcoord_t'(bx_q + BALL_SIZE);
  assign w_by_lo = wcoord_t'(by_q - BALL_SIZE);
  assign w_by_hi = wcoord_t'(by_q + BALL_SIZE);

  assign w_hit1 = vx_neg_q
      && spans_overlap(w_bx_lo, w_bx_hi, box_lo(Paddle1X, Paddle1W), box_hi(Paddle1X, Paddle1W))
      && spans_overlap(w_by_lo, w_by_hi, box_lo(Paddle1Y, Paddle1L), box_hi(Paddle1Y, Paddle1L));
  assign w_hit2 = !vx_neg_q
      && spans_overlap(w_bx_lo, w_bx_hi, box_lo(Paddle2X, Paddle2W), box_hi(Paddle2X, Paddle2W))
      && spans_overlap(w_by_lo, w_by_hi, box_lo(Paddle2Y, Paddle2L), box_hi(Paddle2Y, Paddle2L));

  assign w_miss_l = vx_neg_q  && !w_hit1 && (bx_q - BALL_SIZE <= X_MIN);
  assign w_miss_r = !vx_neg_q && !w_hit2 && (bx_q + BALL_SIZE >= X_MAX);

  assign w_vx_nxt_neg = w_hit1 ? 1'b0 : (w_hit2 ? 1'b1 : vx_neg_q);
  assign w_x_new      = bx_q + (w_vx_nxt_neg ? -STEP : STEP);

  logic [3:0] w_point_score;
  assign w_point_score = left_scored_q ? sat_inc(score1_q) : sat_inc(score2_q);

  // ---- Next-state logic ----
  always_comb begin
    state_d       = state_q;
    bx_d          = bx_q;
    by_d          = by_q;
    vx_neg_d      = vx_neg_q;
    vy_neg_d      = vy_neg_q;
    cnt_d         = cnt_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    left_scored_d = left_scored_q;

    unique case (state_q)
      ST_IDLE: begin
        if (serve_btn) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end

      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          if (w_miss_l || w_miss_r) begin
            // Ball frozen on the miss tick; POINT recentres it next cycle.
            state_d       = ST_POINT;
            left_scored_d = w_miss_r;
          end else begin
            bx_d     = w_x_new;
            by_d     = w_y_new;
            vx_neg_d = w_vx_nxt_neg;
            vy_neg_d = w_vy_nxt_neg;
          end
        end
      end

      ST_POINT: begin
        if (left_scored_q) score1_d = w_point_score;
        else               score2_d = w_point_score;
        bx_d     = CENTER_X;
        by_d     = CENTER_Y;
        // Serve toward the player who just lost the point.
        vx_neg_d = !left_scored_q;
        vy_neg_d = 1'b0;
        cnt_d    = '0;
        state_d  = (w_point_score == WIN_SCORE) ? ST_OVER : ST_SERVE;
      end

      ST_OVER: begin
        if (serve_btn) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          vx_neg_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign BallX     = bx_q[9:0];
  assign BallY     = by_q[9:0];
  assign Ball_size = BALL_SIZE[9:0];
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = (state_q == ST_OVER);
  assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_ball_ctrl
// Description : Self-checking bench for pong_ball_ctrl: a startup vector
//               table, directed bounce/miss/game-over/reset sequences and a
//               randomized run, all compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_ball_ctrl;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, serve_btn;
  logic [9:0] Paddle1X, Paddle1Y, Paddle1L, Paddle1W;
  logic [9:0] Paddle2X, Paddle2Y, Paddle2L, Paddle2W;
  logic [9:0] BallX, BallY, Ball_size;
  logic [3:0] score1, score2;
  logic       game_over;
  logic [2:0] state_dbg;

  pong_ball_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .serve_btn(serve_btn),
    .Paddle1X(Paddle1X), .Paddle1Y(Paddle1Y), .Paddle1L(Paddle1L), .Paddle1W(Paddle1W),
    .Paddle2X(Paddle2X), .Paddle2Y(Paddle2Y), .Paddle2L(Paddle2L), .Paddle2W(Paddle2W),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
    .score1(score1), .score2(score2), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  int m_st, m_bx, m_by, m_vx, m_vy, m_cnt, m_s1, m_s2;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_bx = 320; m_by = 240; m_vx = 2; m_vy = 2;
    m_cnt = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_press();
    if (m_st == IDLE) begin
      m_st = SERVE; m_cnt = 0;
    end else if (m_st == OVER) begin
      m_s1 = 0; m_s2 = 0; m_vx = 2; m_cnt = 0; m_st = SERVE;
    end
  endtask

  // Two boxes given as centre +/- half-extent touch when the centre
  // distance is within the summed half-extents on both axes.
  function automatic bit boxes_touch(int ax, int ay, int ahx, int ahy,
                                     int bx, int by, int bhx, int bhy);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx <= ahx + bhx) && (dy <= ahy + bhy);
  endfunction

  task automatic model_point(input bit left);
    if (left) m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1;
    else      m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1;
    m_bx = 320; m_by = 240;
    m_vx = left ? 2 : -2;
    m_vy = 2; m_cnt = 0;
    m_st = ((left ? m_s1 : m_s2) == 9) ? OVER : SERVE;
  endtask

  task automatic model_tick();
    int nvx, nvy;
    if (m_st == SERVE) begin
      if (m_cnt == 59) m_st = PLAY; else m_cnt++;
    end else if (m_st == PLAY) begin
      nvy = m_vy;
      if (m_vy > 0 && m_by + 4 >= 479) nvy = -2;
      else if (m_vy < 0 && m_by - 4 <= 0) nvy = 2;
      nvx = m_vx;
      if (m_vx < 0 && boxes_touch(m_bx, m_by, 4, 4, Paddle1X, Paddle1Y, Paddle1W, Paddle1L))
        nvx = 2;
      else if (m_vx > 0 && boxes_touch(m_bx, m_by, 4, 4, Paddle2X, Paddle2Y, Paddle2W, Paddle2L))
        nvx = -2;
      else if (m_vx < 0 && m_bx - 4 <= 0) begin
        model_point(1'b0); return;
      end else if (m_vx > 0 && m_bx + 4 >= 639) begin
        model_point(1'b1); return;
      end
      m_vx = nvx; m_vy = nvy;
      m_bx += nvx;
      m_by += nvy;
      if (m_by < 4)   m_by = 4;
      if (m_by > 475) m_by = 475;
    end
  endtask

  task automatic compare_all();
    check("BallX", BallX, m_bx);
    check("BallY", BallY, m_by);
    check("score1", score1, m_s1);
    check("score2", score2, m_s2);
    check("state", state_dbg, m_st);
    check("game_over", game_over, (m_st == OVER) ? 1 : 0);
    check("Ball_size", Ball_size, 4);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic frame(input int hi, input int lo);
    frame_clk = 1'b1;
    repeat (hi) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (lo) @(posedge Clk);
    #1;
    model_tick();
    compare_all();
  endtask

  task automatic press();
    serve_btn = 1'b1;
    @(posedge Clk);
    #1 serve_btn = 1'b0;
    model_press();
    compare_all();
  endtask

  task automatic paddles(input int x1, input int y1, input int l1, input int w1,
                         input int x2, input int y2, input int l2, input int w2);
    Paddle1X = 10'(x1); Paddle1Y = 10'(y1); Paddle1L = 10'(l1); Paddle1W = 10'(w1);
    Paddle2X = 10'(x2); Paddle2Y = 10'(y2); Paddle2L = 10'(l2); Paddle2W = 10'(w2);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit press;
    int frames;
    int ebx;
    int eby;
    int est;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int max_x;
    tbl[0] = '{1'b0, 10, 320, 240, IDLE};
    tbl[1] = '{1'b1, 59, 320, 240, SERVE};
    tbl[2] = '{1'b0,  1, 320, 240, PLAY};
    tbl[3] = '{1'b0,  1, 322, 242, PLAY};
    tbl[4] = '{1'b0,  5, 332, 252, PLAY};

    Reset = 1'b1; frame_clk = 1'b0; serve_btn = 1'b0;
    paddles(1000, 0, 0, 0, 1000, 0, 0, 0);
    model_reset();
    #1;
    compare_all();                       // asynchronous reset values
    @(posedge Clk); #1 Reset = 1'b0;

    // ---- startup table: idle, serve hold, launch ----
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].press) press();
      for (int f = 0; f < tbl[i].frames; f++) frame(4, 4);
      check($sformatf("vec%0d_x", i), BallX, tbl[i].ebx);
      check($sformatf("vec%0d_y", i), BallY, tbl[i].eby);
      check($sformatf("vec%0d_st", i), state_dbg, tbl[i].est);
    end

    // ---- tick latency: update lands on the 3rd Clk edge after frame_clk ----
    frame_clk = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); #1;
      check($sformatf("latency_edge%0d", k), BallX, (k < 3) ? 332 : 334);
    end
    repeat (5) @(posedge Clk);           // long high: still only one step
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    model_tick();
    compare_all();

    // ---- right paddle bounce at x=596 face ----
    paddles(1000, 0, 0, 0, 600, 240, 300, 4);
    max_x = 0;
    for (int f = 0; f < 140; f++) begin
      frame(4, 4);
      if (BallX > max_x) max_x = BallX;
    end
    check("bounce_max_x", max_x, 592);
    check("bounce_no_score", score1 + score2, 0);

    // ---- left wall, right paddle out of reach: left player scores ----
    paddles(20, 240, 300, 4, 600, 1000, 30, 4);
    for (int f = 0; f < 1500 && m_s1 == 0; f++) frame(4, 4);
    check("miss_score1", score1, 1);
    check("miss_state", state_dbg, SERVE);
    check("miss_center_x", BallX, 320);

    // ---- asynchronous reset in the middle of PLAY ----
    for (int f = 0; f < 65; f++) frame(4, 4);
    check("pre_reset_play", state_dbg, PLAY);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("async_rst_x", BallX, 320);
    check("async_rst_y", BallY, 240);
    check("async_rst_s1", score1, 0);
    check("async_rst_st", state_dbg, IDLE);
    @(posedge Clk); #1 Reset = 1'b0;
    model_reset();
    frame(4, 4);

    // ---- full game to WIN_SCORE ----
    press();
    for (int f = 0; f < 2600 && m_st != OVER; f++) frame(4, 4);
    check("reach_over", game_over, 1);
    check("over_score1", score1, 9);
    for (int f = 0; f < 3; f++) frame(4, 4);
    check("over_hold_s1", score1, 9);
    press();
    check("restart_s1", score1, 0);
    check("restart_state", state_dbg, SERVE);
    press();                              // ignored while serving
    check("serve_ignores_btn", state_dbg, SERVE);

    // ---- randomized play ----
    do_reset();
    compare_all();
    for (int f = 0; f < 2000; f++) begin
      if (f % 150 == 0) begin
        if ($urandom_range(0, 4) == 0)
          paddles(1000, 0, 0, 0, $urandom_range(580, 634), $urandom_range(0, 479),
                  $urandom_range(5, 120), $urandom_range(1, 8));
        else
          paddles($urandom_range(5, 60), $urandom_range(0, 479), $urandom_range(5, 120),
                  $urandom_range(1, 8), $urandom_range(580, 634), $urandom_range(0, 479),
                  $urandom_range(5, 120), $urandom_range(1, 8));
      end
      if ($urandom_range(0, 59) == 0) press();
      frame($urandom_range(3, 6), $urandom_range(3, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
